// File: rtl/complex_accum_dump_if.sv
// ----------------------------------------------------------------------------
// complex_accum_dump_if
// Bus bundle for the complex accumulate-and-dump stage.
//   enable        : clock-enable; low freezes all state in the consumer
//   p_i / p_q     : signed 32-bit I/Q products from the complex multiplier
//   input_valid   : product valid strobe
//   window_len    : samples per window (sampled at window start)
//   shift         : right-shift for the scaled outputs (sampled at window start)
//   sum_i / sum_q : signed ACC_WIDTH window sums
//   scaled_i/_q   : rounded, saturated OUT_WIDTH scaled sums
//   overflow      : accumulator saturated during the dumped window
//   output_valid  : one-cycle strobe qualifying all outputs
// The master modport belongs to the producer/observer, the slave modport to
// the accumulate-and-dump block.
// ----------------------------------------------------------------------------
interface complex_accum_dump_if #(
    parameter int ACC_WIDTH = 40,
    parameter int OUT_WIDTH = 16,
    parameter int LEN_WIDTH = 16
);
    logic                        enable;
    logic signed [31:0]          p_i;
    logic signed [31:0]          p_q;
    logic                        input_valid;
    logic [LEN_WIDTH-1:0]        window_len;
    logic [4:0]                  shift;
    logic signed [ACC_WIDTH-1:0] sum_i;
    logic signed [ACC_WIDTH-1:0] sum_q;
    logic signed [OUT_WIDTH-1:0] scaled_i;
    logic signed [OUT_WIDTH-1:0] scaled_q;
    logic                        overflow;
    logic                        output_valid;

    modport master (
        output enable, p_i, p_q, input_valid, window_len, shift,
        input  sum_i, sum_q, scaled_i, scaled_q, overflow, output_valid
    );

    modport slave (
        input  enable, p_i, p_q, input_valid, window_len, shift,
        output sum_i, sum_q, scaled_i, scaled_q, overflow, output_valid
    );
endinterface

// File: rtl/complex_accum_dump.sv
// ----------------------------------------------------------------------------
// complex_accum_dump
// Sums window_len consecutive valid I/Q products with saturation, then dumps
// the wide sums plus a round-half-up, saturated, right-shifted version.
// Ports:
//   clock : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : complex_accum_dump_if.slave (products in, sums/scaled out)
// Output latency is two enabled cycles after the edge that captures the
// completing sample. Windows may run back to back with no bubble.
// ----------------------------------------------------------------------------
module complex_accum_dump #(
    parameter int ACC_WIDTH = 40,
    parameter int OUT_WIDTH = 16,
    parameter int LEN_WIDTH = 16
) (
    input logic                  clock,
    input logic                  reset,
    complex_accum_dump_if.slave  bus
);
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ACCUM = 1'b1;

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    localparam logic [ACC_WIDTH:0]          ONE_W   = 1;

    logic [0:0]                  state_reg;
    logic [LEN_WIDTH-1:0]        len_reg;
    logic [LEN_WIDTH-1:0]        count_reg;
    logic [4:0]                  shift_reg;
    logic                        ovf_reg;
    logic                        done_reg;
    logic signed [ACC_WIDTH-1:0] acc_reg [2];

    logic                        s1_valid_reg;
    logic [4:0]                  s1_shift_reg;
    logic                        s1_ovf_reg;
    logic signed [ACC_WIDTH-1:0] s1_sum_reg [2];

    logic                        out_valid_reg;
    logic                        out_ovf_reg;
    logic signed [ACC_WIDTH-1:0] out_sum_reg [2];
    logic signed [OUT_WIDTH-1:0] out_scaled_reg [2];

    logic signed [31:0]          p_ch [2];
    logic signed [ACC_WIDTH-1:0] acc_sat [2];
    logic                        sat_hit [2];
    logic signed [OUT_WIDTH-1:0] scaled_ch [2];
    logic [LEN_WIDTH:0]          count_inc;

    assign p_ch[0]   = bus.p_i;
    assign p_ch[1]   = bus.p_q;
    assign count_inc = {1'b0, count_reg} + 1'b1;

    // Per-channel saturating add and round/shift/saturate scaling.
    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
        logic signed [ACC_WIDTH:0] wide_sum;
        logic [ACC_WIDTH:0]        round_add;
        logic signed [ACC_WIDTH:0] rounded;
        logic signed [ACC_WIDTH:0] shifted;
        logic                      fits;

        // One guard bit: overflow shows up as the top two bits disagreeing.
        assign wide_sum = {acc_reg[gi][ACC_WIDTH-1], acc_reg[gi]}
                        + {{(ACC_WIDTH+1-32){p_ch[gi][31]}}, p_ch[gi]};
        assign sat_hit[gi] = wide_sum[ACC_WIDTH] ^ wide_sum[ACC_WIDTH-1];
        assign acc_sat[gi] = sat_hit[gi] ? (wide_sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX)
                                         : wide_sum[ACC_WIDTH-1:0];

        // Half-LSB bias before the arithmetic shift gives round-half-up.
        assign round_add = (s1_shift_reg == 5'd0) ? '0 : (ONE_W << (s1_shift_reg - 5'd1));
        assign rounded   = {s1_sum_reg[gi][ACC_WIDTH-1], s1_sum_reg[gi]} + $signed(round_add);
        assign shifted   = rounded >>> s1_shift_reg;
        // Value fits when every bit above the output sign bit equals it.
        assign fits      = (&shifted[ACC_WIDTH:OUT_WIDTH-1]) | ~(|shifted[ACC_WIDTH:OUT_WIDTH-1]);
        assign scaled_ch[gi] = fits ? shifted[OUT_WIDTH-1:0]
                                    : (shifted[ACC_WIDTH] ? OUT_MIN : OUT_MAX);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            len_reg       <= '0;
            count_reg     <= '0;
            shift_reg     <= '0;
            ovf_reg       <= 1'b0;
            done_reg      <= 1'b0;
            s1_valid_reg  <= 1'b0;
            s1_shift_reg  <= '0;
            s1_ovf_reg    <= 1'b0;
            out_valid_reg <= 1'b0;
            out_ovf_reg   <= 1'b0;
            for (int k = 0; k < 2; k++) begin
                acc_reg[k]        <= '0;
                s1_sum_reg[k]     <= '0;
                out_sum_reg[k]    <= '0;
                out_scaled_reg[k] <= '0;
            end
        end else if (bus.enable) begin
            done_reg <= 1'b0;
            if (bus.input_valid) begin
                if (state_reg == ST_IDLE) begin
                    if (bus.window_len != '0) begin
                        len_reg   <= bus.window_len;
                        shift_reg <= bus.shift;
                        count_reg <= {{(LEN_WIDTH-1){1'b0}}, 1'b1};
                        ovf_reg   <= 1'b0;
                        for (int k = 0; k < 2; k++) begin
                            acc_reg[k] <= {{(ACC_WIDTH-32){p_ch[k][31]}}, p_ch[k]};
                        end
                        if (bus.window_len == {{(LEN_WIDTH-1){1'b0}}, 1'b1}) begin
                            done_reg <= 1'b1;
                        end else begin
                            state_reg <= ST_ACCUM;
                        end
                    end
                end else begin
                    count_reg <= count_inc[LEN_WIDTH-1:0];
                    ovf_reg   <= ovf_reg | sat_hit[0] | sat_hit[1];
                    for (int k = 0; k < 2; k++) begin
                        acc_reg[k] <= acc_sat[k];
                    end
                    if (count_inc == {1'b0, len_reg}) begin
                        done_reg  <= 1'b1;
                        state_reg <= ST_IDLE;
                    end
                end
            end

            // Stage 1 snapshots the finished window before a new one overwrites it.
            s1_valid_reg <= done_reg;
            if (done_reg) begin
                s1_shift_reg <= shift_reg;
                s1_ovf_reg   <= ovf_reg;
                for (int k = 0; k < 2; k++) begin
                    s1_sum_reg[k] <= acc_reg[k];
                end
            end

            out_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                out_ovf_reg <= s1_ovf_reg;
                for (int k = 0; k < 2; k++) begin
                    out_sum_reg[k]    <= s1_sum_reg[k];
                    out_scaled_reg[k] <= scaled_ch[k];
                end
            end
        end
    end

    assign bus.sum_i        = out_sum_reg[0];
    assign bus.sum_q        = out_sum_reg[1];
    assign bus.scaled_i     = out_scaled_reg[0];
    assign bus.scaled_q     = out_scaled_reg[1];
    assign bus.overflow     = out_ovf_reg;
    // The strobe is held in a register but only presented on enabled cycles.
    assign bus.output_valid = out_valid_reg & bus.enable;
endmodule

// File: tb/tb_complex_accum_dump.sv
// ----------------------------------------------------------------------------
// tb_complex_accum_dump
// Directed and randomized stimulus for complex_accum_dump, checked against a
// behavioural window model kept in the bench.
// ----------------------------------------------------------------------------
module tb_complex_accum_dump;
    localparam int AW = 40;
    localparam int OW = 16;
    localparam int LW = 16;
    localparam longint ACC_MAX = (64'sd1 <<< (AW - 1)) - 1;
    localparam longint ACC_MIN = -(64'sd1 <<< (AW - 1));
    localparam longint OUT_MAX = (64'sd1 <<< (OW - 1)) - 1;
    localparam longint OUT_MIN = -(64'sd1 <<< (OW - 1));

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    complex_accum_dump_if #(.ACC_WIDTH(AW), .OUT_WIDTH(OW), .LEN_WIDTH(LW)) bus ();

    complex_accum_dump #(.ACC_WIDTH(AW), .OUT_WIDTH(OW), .LEN_WIDTH(LW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int     due;
        longint si;
        longint sq;
        longint ci;
        longint cq;
        bit     ovf;
    } dump_t;

    dump_t  exp_q[$];
    bit     m_in_win;
    int     m_len, m_shf, m_cnt, en_edges;
    longint m_acc_i, m_acc_q;
    bit     m_ovf;
    longint last_si, last_sq, last_ci, last_cq;
    bit     last_ovf;

    function automatic longint clamp(input longint v, input longint lo, input longint hi);
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    function automatic longint scale(input longint s, input int sh);
        longint r;
        r = s + ((sh != 0) ? (64'sd1 <<< (sh - 1)) : 64'sd0);
        r = r >>> sh;
        return clamp(r, OUT_MIN, OUT_MAX);
    endfunction

    function automatic longint sat_add(input longint a, input longint b, inout bit ovf);
        longint s;
        s = a + b;
        if (s > ACC_MAX || s < ACC_MIN) ovf = 1'b1;
        return clamp(s, ACC_MIN, ACC_MAX);
    endfunction

    task automatic model_clear();
        m_in_win = 0; m_len = 0; m_shf = 0; m_cnt = 0;
        m_acc_i = 0; m_acc_q = 0; m_ovf = 0;
        exp_q.delete();
        last_si = 0; last_sq = 0; last_ci = 0; last_cq = 0; last_ovf = 0;
    endtask

    task automatic model_edge(input bit en, input bit v, input int pi, input int pq,
                              input int wl, input int sh);
        dump_t d;
        bit    done;
        if (!en) return;
        en_edges++;
        if (!v) return;
        done = 0;
        if (!m_in_win) begin
            if (wl == 0) return;
            m_len = wl; m_shf = sh; m_cnt = 1; m_ovf = 0;
            m_acc_i = pi; m_acc_q = pq;
            if (m_len == 1) done = 1;
            else m_in_win = 1;
        end else begin
            m_acc_i = sat_add(m_acc_i, longint'(pi), m_ovf);
            m_acc_q = sat_add(m_acc_q, longint'(pq), m_ovf);
            m_cnt++;
            if (m_cnt == m_len) begin
                done = 1;
                m_in_win = 0;
            end
        end
        if (done) begin
            d.due = en_edges + 2;
            d.si  = m_acc_i;
            d.sq  = m_acc_q;
            d.ci  = scale(m_acc_i, m_shf);
            d.cq  = scale(m_acc_q, m_shf);
            d.ovf = m_ovf;
            exp_q.push_back(d);
        end
    endtask

    // Outputs refresh at the due edge whatever enable is; the strobe only shows while enabled.
    task automatic check_outputs();
        bit exp_v;
        exp_v = 0;
        if (exp_q.size() > 0 && exp_q[0].due == en_edges) begin
            last_si = exp_q[0].si; last_sq = exp_q[0].sq;
            last_ci = exp_q[0].ci; last_cq = exp_q[0].cq;
            last_ovf = exp_q[0].ovf;
            if (bus.enable) begin
                exp_v = 1;
                void'(exp_q.pop_front());
            end
        end
        check_val("output_valid", longint'(bus.output_valid), longint'(exp_v));
        check_val("sum_i", bus.sum_i, last_si);
        check_val("sum_q", bus.sum_q, last_sq);
        check_val("scaled_i", bus.scaled_i, last_ci);
        check_val("scaled_q", bus.scaled_q, last_cq);
        check_val("overflow", longint'(bus.overflow), longint'(last_ovf));
        if (exp_v)
            $display("dump @edge %0d: sum_i=%0d sum_q=%0d scaled=%0d/%0d ovf=%0d",
                     en_edges, last_si, last_sq, last_ci, last_cq, last_ovf);
    endtask

    task automatic step(input bit en, input bit v, input int pi, input int pq,
                        input int wl, input int sh);
        bus.enable      = en;
        bus.input_valid = v;
        bus.p_i         = pi;
        bus.p_q         = pq;
        bus.window_len  = wl[LW-1:0];
        bus.shift       = sh[4:0];
        @(negedge clock);
        check_outputs();
        @(posedge clock);
        model_edge(en, v, pi, pq, wl, sh);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        bus.enable = 0; bus.input_valid = 0;
        reset = 1;
        @(posedge clock);
        #1;
        reset = 0;
        model_clear();
    endtask

    initial begin
        reset = 1;
        bus.enable = 0; bus.input_valid = 0; bus.p_i = 0; bus.p_q = 0;
        bus.window_len = '0; bus.shift = '0;
        en_edges = 0;
        model_clear();
        repeat (2) @(posedge clock);
        #1;
        do_reset();
        idle(3);

        // Length 4, shift 0, ramp on I, constant -1 on Q.
        for (int i = 1; i <= 4; i++) step(1, 1, i, -1, 4, 0);
        idle(4);

        // Length 3, shift 2, two idle cycles between samples.
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 3, 0, 3, 2);
            idle(2);
        end
        idle(3);

        // Length 2 of full-scale positive: fits the accumulator, scaled saturates.
        for (int i = 0; i < 2; i++) step(1, 1, 32'h7FFFFFFF, 32'h80000000, 2, 0);
        idle(4);

        // Length 512 of full-scale: accumulator clamps, overflow set.
        for (int i = 0; i < 512; i++) step(1, 1, 32'h7FFFFFFF, 32'h80000000, 512, 0);
        idle(4);

        // Back-to-back length 2; length 3 presented from sample 4 onward.
        for (int i = 1; i <= 7; i++) step(1, 1, 1, i, (i <= 3) ? 2 : 3, 1);
        idle(4);

        // Reset mid-window discards it; the following window is clean.
        for (int i = 0; i < 2; i++) step(1, 1, 5, 7, 4, 0);
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 1, 5, 7, 4, 0);
        idle(4);

        // Enable low mid-window and during the output pipeline.
        step(1, 1, 9, -9, 3, 1);
        step(0, 1, 100, 100, 3, 1);
        step(0, 1, 100, 100, 3, 1);
        step(1, 1, 9, -9, 3, 1);
        step(1, 1, 9, -9, 3, 1);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        idle(4);

        // window_len 0 drops samples; window_len 1 dumps every sample.
        step(1, 1, 50, 50, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 1, i * 1000 - 2000, -i * 77, 1, i);
        idle(4);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            bit en, v;
            int pi, pq, wl, sh, sel;
            en  = ($urandom % 8) != 0;
            v   = ($urandom % 3) != 0;
            sel = int'($urandom % 4);
            pi  = (sel == 0) ? 32'h7FFFFFFF : ((sel == 1) ? 32'h80000000 : int'($urandom));
            pq  = (sel == 2) ? int'($urandom_range(0, 2000)) - 1000 : int'($urandom);
            wl  = (($urandom % 40) == 0) ? int'($urandom_range(200, 400))
                                         : int'($urandom_range(0, 6));
            sh  = int'($urandom_range(0, 31));
            if (($urandom % 700) == 0) do_reset();
            else step(en, v, pi, pq, wl, sh);
        end
        idle(6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/complex_accum_dump.md
Name: complex_accum_dump

Overview:
- Accumulate-and-dump stage that sits directly downstream of the complex multiplier and consumes its 32-bit I/Q products plus their valid strobe.
- Sums WINDOW_LEN consecutive valid products per channel with saturation, then emits the wide sums and a rounded, saturated 16-bit scaled version.
- Used for correlation and channel-estimate averaging ahead of the detection logic.

Parameters:
- ACC_WIDTH, 40, signed accumulator and sum output width; must be >= 33.
- OUT_WIDTH, 16, signed width of the scaled outputs.
- LEN_WIDTH, 16, width of the window-length input.

Ports:
- clock  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- enable  input  1  clock-enable; when low all state is frozen
- p_i  input  32  signed in-phase product
- p_q  input  32  signed quadrature product
- input_valid  input  1  product valid strobe
- window_len  input  LEN_WIDTH  unsigned number of samples per window; sampled at window start
- shift  input  5  right-shift applied to the sums for the scaled outputs; sampled at window start
- sum_i  output  ACC_WIDTH  signed window sum, I
- sum_q  output  ACC_WIDTH  signed window sum, Q
- scaled_i  output  OUT_WIDTH  round(sum_i >>> shift), saturated
- scaled_q  output  OUT_WIDTH  round(sum_q >>> shift), saturated
- overflow  output  1  accumulator saturated at least once during this window
- output_valid  output  1  one-cycle strobe qualifying all outputs

Behaviour:
- Reset:
  - State goes to IDLE; accumulators and counter are cleared.
  - sum_i, sum_q, scaled_i, scaled_q, overflow and output_valid are all 0.
- enable low:
  - No register changes and input_valid is ignored.
  - output_valid is driven 0.
  - Resuming continues exactly where the block stopped.
- States: IDLE and ACCUM. A valid sample means a cycle with enable=1 and input_valid=1.
- IDLE:
  - On a valid sample with window_len != 0: latch len and shift, set acc to sign-extend(p), set count=1, clear the sticky overflow flag.
  - If len==1 the window completes on this same sample; otherwise go to ACCUM.
  - If window_len==0 the sample is dropped and the block stays in IDLE.
- ACCUM:
  - On a valid sample: acc <= sat(acc + p), count <= count+1.
  - When count+1 == len the window completes, and the block returns to IDLE (or immediately restarts, see below).
  - Cycles without a valid sample leave the state untouched; there is no timeout.
- Saturation: if the ACC_WIDTH add overflows, clamp to max/min signed and set the sticky overflow flag for that channel-pair window (I or Q).
- Back-to-back windows:
  - The valid sample on the cycle after the completing sample starts a new window with no bubble.
  - New window_len and shift are latched at that point.
  - Changing window_len mid-window has no effect on the current window.
- Output pipeline (latency 2 cycles from the completing sample's clock edge):
  - Stage 1 registers the final sums, the latched shift and the overflow flag.
  - Stage 2 computes scaled = (sum + (shift ? 1<<(shift-1) : 0)) >>> shift, a round-half-up arithmetic shift.
  - The scaled result saturates to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - Stage 2 registers sum_*, scaled_*, overflow, and output_valid=1 for exactly one enabled cycle.
  - Outputs hold their values until the next dump.
- The output pipeline advances only when enable=1.
- Reset mid-window or mid-pipeline discards the partial sums and any pending output; no output_valid is produced for it.
- window_len=1 gives one output per valid sample, sustaining full rate.

Test Plan:
- Length 4, shift 0, p_i=1,2,3,4 and p_q=-1,-1,-1,-1 on consecutive cycles -> 2 cycles after the 4th sample: sum_i=10, sum_q=-4, scaled 10/-4, overflow=0, a single valid pulse.
- Length 3, shift 2, p_i=3 on each sample with gaps of 2 idle cycles between samples -> sum_i=9, scaled_i=2 (9+2=11>>2); gaps do not alter the result.
- Length 2, shift 0, p_i=0x7FFFFFFF x2 -> sum_i=0xFFFFFFFE (fits in 40 bits), scaled_i=32767 (saturated), overflow=0.
- Length 512, p_i=0x7FFFFFFF on every sample -> acc clamps at 2^39-1, overflow=1, scaled_i=32767 with shift 0.
- Back-to-back: window_len=2 with 6 continuous samples of 1 -> three output_valid pulses on consecutive-odd cycles, each with sum_i=2. Changing window_len to 3 after sample 3 only affects the window starting at sample 5.
- Reset asserted after 2 of 4 samples, then 4 samples of 5 -> no output for the aborted window; the next output has sum_i=20. Toggling enable low mid-window freezes the count and output_valid stays 0 while enable is low.
